frame_set_writer: RTL and testbench
===================================

# frame_set_writer

Producer side of the frame-settings update interface. It accepts host register writes into shadow registers. On a commit it drives source_choose, framedat_length, trace_length and retrace_length stable, then raises update_flag for a stretched window. The stretch lets a downstream settings latch sample the rising edge through a two-flop synchronizer and capture the values, even from a slower or unrelated clock.

## Interface
- SETUP_CYC, 2: cycles values are stable before update_flag rises (1..255)
- PULSE_CYC, 4: cycles update_flag is held high (1..255)
- HOLD_CYC, 4: cycles values are held after update_flag falls (1..255)
- MAX_SOURCE, 4: highest legal source_choose code (used only with range check)
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  host write strobe, one write per high cycle
- wr_addr  in  3  0=source_choose, 1=framedat_length, 2=trace_length, 3=retrace_length, 4=commit, 5..7 ignored
- wr_data  in  16  write data; address 0 uses bits [2:0]
- source_choose  out  3  published source select
- framedat_length  out  16  published frame data length
- trace_length  out  16  published trace length
- retrace_length  out  16  published retrace length
- update_flag  out  1  registered update strobe, high for PULSE_CYC cycles
- busy  out  1  registered; high while a publish sequence is in progress
- cfg_err  out  1  registered; one-cycle pulse on a rejected commit

## Operation
- Shadow registers (3+16+16+16 bits) are written on wr_en for addresses 0..3 at any time, including while busy. A shadow write never disturbs the published outputs.
- A commit (wr_en with wr_addr=4) is accepted in IDLE.
  - At that edge the published outputs load from the shadow registers, busy is set, and the block enters SETUP.
- FSM states: IDLE, SETUP, PULSE, HOLD. One 8-bit down-counter is shared across states.
  - SETUP: counts SETUP_CYC cycles, then enters PULSE.
  - PULSE: update_flag=1, counts PULSE_CYC cycles, then enters HOLD.
  - HOLD: update_flag=0, counts HOLD_CYC cycles.
- At the end of HOLD:
  - If a commit is pending, the block clears pending, reloads the outputs from the shadow registers, and re-enters SETUP. busy stays high.
  - Otherwise the block enters IDLE and clears busy.
- A commit while busy sets a single pending bit. Further commits while pending is set merge into it. Only the shadow contents at reload time are published.
- Published outputs change only on the load edge. They are constant throughout SETUP, PULSE and HOLD.
- A shadow write and a commit cannot occur in the same cycle, because there is one address per cycle.
- Reset values: all outputs 0, all shadow registers 0, pending 0, counter 0, state IDLE.
- An asynchronous reset mid-sequence clears everything immediately. update_flag drops without completing its pulse.

## Timing
- Commit is sampled at edge T:
  - busy=1 and the new values are visible after edge T.
  - update_flag rises after edge T+SETUP_CYC.
  - update_flag falls after edge T+SETUP_CYC+PULSE_CYC.
  - busy falls after edge T+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- Total busy duration: SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- Back-to-back with pending: the next value load happens at the edge that ends HOLD. There is no idle cycle between sequences.
- update_flag is never high on the cycle the outputs change. It is low for at least HOLD_CYC+SETUP_CYC cycles between pulses.

## Configuration
- FRAME_SET_RANGE_CHECK_EN defined:
  - A commit is rejected if shadow source_choose > MAX_SOURCE, or if shadow framedat_length, trace_length or retrace_length equals 0.
  - On reject: cfg_err pulses for one cycle after the commit edge, and outputs, state and busy are unchanged.
  - A pending commit is checked at its reload point. If rejected, cfg_err pulses and the block enters IDLE.
- FRAME_SET_RANGE_CHECK_EN undefined:
  - cfg_err is tied to 0 and all commits are accepted.

## Test plan
- Reset, then write addresses 0..3 with 3, 0x0400, 0x0320, 0x0040, then commit at edge T (defaults) -> outputs show 3/0x0400/0x0320/0x0040 after T. update_flag is high after T+2 through T+5. busy is high after T through T+9.
- Shadow write of trace_length=0x0111 during PULSE -> published trace_length stays 0x0320 until the next commit.
- Commit during PULSE, then shadow retrace_length=0x0080, then a second commit during HOLD -> exactly one extra sequence. It loads 0x0080 at the HOLD-end edge, busy stays high continuously, and update_flag gives two separate 4-cycle pulses.
- reset_n low during PULSE -> update_flag, busy and all outputs are 0 immediately. Re-commit after release gives full normal timing.
- With FRAME_SET_RANGE_CHECK_EN: source_choose=5, then commit -> cfg_err pulses once, busy stays 0, outputs unchanged. With the macro undefined, the same stimulus publishes 5.
- SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1: commit -> update_flag is high for exactly one cycle after T+1, and busy is high for 3 cycles.

Source files
------------

// File: rtl/frame_set_writer.sv
// Frame-settings producer: shadow registers published on commit, then a stretched
// update_flag pulse. Optional commit validation under FRAME_SET_RANGE_CHECK_EN.
module frame_set_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int HOLD_CYC   = 4,
  parameter int MAX_SOURCE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [2:0]  source_choose,
  output logic [15:0] framedat_length,
  output logic [15:0] trace_length,
  output logic [15:0] retrace_length,
  output logic        update_flag,
  output logic        busy,
  output logic        cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} state_e;

  // Counter reload values: each phase lasts (value + 1) cycles.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [2:0] MAX_SRC  = 3'(MAX_SOURCE);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        update_flag_q, update_flag_d;
  logic        cfg_err_q, cfg_err_d;

  logic [2:0]  sh_src_q, sh_src_d;
  logic [15:0] sh_fd_q, sh_fd_d;
  logic [15:0] sh_tr_q, sh_tr_d;
  logic [15:0] sh_rt_q, sh_rt_d;

  logic [2:0]  src_q, src_d;
  logic [15:0] fd_q, fd_d;
  logic [15:0] tr_q, tr_d;
  logic [15:0] rt_q, rt_d;

  logic commit;
  logic load;
  logic range_ok;
  logic accept;

  assign commit   = wr_en && (wr_addr == 3'd4);
  assign range_ok = (sh_src_q <= MAX_SRC) && (sh_fd_q != 16'd0) &&
                    (sh_tr_q != 16'd0) && (sh_rt_q != 16'd0);

`ifdef FRAME_SET_RANGE_CHECK_EN
  assign accept = range_ok;
`else
  logic unused_range_ok;
  assign unused_range_ok = range_ok;
  assign accept          = 1'b1;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    busy_d        = busy_q;
    update_flag_d = 1'b0;
    cfg_err_d     = 1'b0;
    load          = 1'b0;

    sh_src_d = sh_src_q;
    sh_fd_d  = sh_fd_q;
    sh_tr_d  = sh_tr_q;
    sh_rt_d  = sh_rt_q;
    if (wr_en) begin
      case (wr_addr)
        3'd0:    sh_src_d = wr_data[2:0];
        3'd1:    sh_fd_d  = wr_data;
        3'd2:    sh_tr_d  = wr_data;
        3'd3:    sh_rt_d  = wr_data;
        default: ;
      endcase
    end

    // Commits during a sequence collapse into one pending bit.
    if (commit && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          if (accept) begin
            load    = 1'b1;
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            busy_d  = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d       = ST_PULSE;
          cnt_d         = PULSE_LD;
          update_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d         = cnt_q - 8'd1;
          update_flag_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          pending_d = 1'b0;
          // A commit landing on the final HOLD edge is served like a pending one.
          if ((pending_q || commit) && accept) begin
            load    = 1'b1;
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            cfg_err_d = pending_q || commit;
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    src_d = load ? sh_src_q : src_q;
    fd_d  = load ? sh_fd_q  : fd_q;
    tr_d  = load ? sh_tr_q  : tr_q;
    rt_d  = load ? sh_rt_q  : rt_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      update_flag_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      sh_src_q      <= 3'd0;
      sh_fd_q       <= 16'd0;
      sh_tr_q       <= 16'd0;
      sh_rt_q       <= 16'd0;
      src_q         <= 3'd0;
      fd_q          <= 16'd0;
      tr_q          <= 16'd0;
      rt_q          <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      update_flag_q <= update_flag_d;
      cfg_err_q     <= cfg_err_d;
      sh_src_q      <= sh_src_d;
      sh_fd_q       <= sh_fd_d;
      sh_tr_q       <= sh_tr_d;
      sh_rt_q       <= sh_rt_d;
      src_q         <= src_d;
      fd_q          <= fd_d;
      tr_q          <= tr_d;
      rt_q          <= rt_d;
    end
  end

  assign source_choose   = src_q;
  assign framedat_length = fd_q;
  assign trace_length    = tr_q;
  assign retrace_length  = rt_q;
  assign update_flag     = update_flag_q;
  assign busy            = busy_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_frame_set_writer.sv
// Bench for frame_set_writer: timing tables per sequence plus a scoreboard that
// checks the published values at every update_flag rising edge.
module tb_frame_set_writer;

  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'd0;

  logic [2:0]  source_choose;
  logic [15:0] framedat_length, trace_length, retrace_length;
  logic        update_flag, busy, cfg_err;

  logic [2:0]  f_src;
  logic [15:0] f_fd, f_tr, f_rt;
  logic        f_flag, f_busy, f_err;

  frame_set_writer #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .MAX_SOURCE(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .source_choose(source_choose), .framedat_length(framedat_length),
    .trace_length(trace_length), .retrace_length(retrace_length),
    .update_flag(update_flag), .busy(busy), .cfg_err(cfg_err)
  );

  frame_set_writer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .MAX_SOURCE(4)) u_fast (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .source_choose(f_src), .framedat_length(f_fd),
    .trace_length(f_tr), .retrace_length(f_rt),
    .update_flag(f_flag), .busy(f_busy), .cfg_err(f_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [15:0] fd;
    logic [15:0] tr;
    logic [15:0] rt;
  } pub_t;

  typedef struct {
    logic        flag;
    logic        busy;
    logic [15:0] rt;
  } vec_t;

  pub_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: values published must match the expected record at each pulse.
  logic flag_prev = 1'b0;
  always @(negedge clk) begin
    pub_t e;
    if (update_flag && !flag_prev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'(update_flag), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_src", 32'(source_choose),   32'(e.src));
        check("sb_fd",  32'(framedat_length), 32'(e.fd));
        check("sb_tr",  32'(trace_length),    32'(e.tr));
        check("sb_rt",  32'(retrace_length),  32'(e.rt));
      end
    end
    flag_prev = update_flag;
  end

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_shadow(input pub_t p);
    write(3'd0, {13'd0, p.src});
    write(3'd1, p.fd);
    write(3'd2, p.tr);
    write(3'd3, p.rt);
  endtask

  task automatic commit_pub(input pub_t p);
    exp_q.push_back(p);
    write(3'd4, 16'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    pub_t p1, p3a, p3b, p6;
    vec_t tbl1 [0:11];
    vec_t tbl3 [0:21];

    p1  = '{3'd3, 16'h0400, 16'h0320, 16'h0040};
    p3a = '{3'd3, 16'h0400, 16'h0111, 16'h0040};
    p3b = '{3'd3, 16'h0400, 16'h0111, 16'h0080};
    p6  = '{3'd2, 16'h0400, 16'h0320, 16'h0040};
    for (int k = 0; k < 12; k++) begin
      tbl1[k].flag = (k >= S) && (k < S + P);
      tbl1[k].busy = (k < S + P + H);
      tbl1[k].rt   = 16'h0040;
    end
    for (int k = 0; k < 22; k++) begin
      tbl3[k].flag = ((k >= S) && (k < S + P)) ||
                     ((k >= 2 * S + P + H) && (k < 2 * S + 2 * P + H));
      tbl3[k].busy = (k < 2 * (S + P + H));
      tbl3[k].rt   = (k < S + P + H) ? 16'h0040 : 16'h0080;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_flag", 32'(update_flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err",  32'(cfg_err), 32'd0);
    check("rst_src",  32'(source_choose), 32'd0);
    check("rst_fd",   32'(framedat_length), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic publish with default timing
    load_shadow(p1);
    check("shadow_no_publish", 32'(framedat_length), 32'd0);
    commit_pub(p1);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t1_flag_k%0d", k), 32'(update_flag), 32'(tbl1[k].flag));
      check($sformatf("t1_busy_k%0d", k), 32'(busy), 32'(tbl1[k].busy));
      check($sformatf("t1_tr_k%0d", k), 32'(trace_length), 32'h0320);
      @(negedge clk);
    end

    // Shadow write during PULSE leaves published value alone
    commit_pub(p1);
    repeat (S) @(negedge clk);
    check("t2_in_pulse", 32'(update_flag), 32'd1);
    write(3'd2, 16'h0111);
    check("t2_tr_during", 32'(trace_length), 32'h0320);
    wait_idle(40);
    check("t2_tr_after", 32'(trace_length), 32'h0320);
    @(negedge clk);

    // Pending commit plus merged commit: exactly one extra sequence
    commit_pub(p3a);
    for (int k = 0; k < 22; k++) begin
      check($sformatf("t3_flag_k%0d", k), 32'(update_flag), 32'(tbl3[k].flag));
      check($sformatf("t3_busy_k%0d", k), 32'(busy), 32'(tbl3[k].busy));
      check($sformatf("t3_rt_k%0d", k), 32'(retrace_length), 32'(tbl3[k].rt));
      if (k == S + 1) begin
        exp_q.push_back(p3b);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd0;
      end else if (k == S + 2) begin
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h0080;
      end else if (k == S + P + 1) begin
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd0;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during PULSE
    commit_pub(p3b);
    repeat (S + 1) @(negedge clk);
    check("t4_in_pulse", 32'(update_flag), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t4_rst_flag", 32'(update_flag), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_src",  32'(source_choose), 32'd0);
    check("t4_rst_fd",   32'(framedat_length), 32'd0);
    check("t4_rst_tr",   32'(trace_length), 32'd0);
    check("t4_rst_rt",   32'(retrace_length), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_shadow(p1);
    commit_pub(p1);
    check("t4_k0_busy", 32'(busy), 32'd1);
    check("t4_k0_flag", 32'(update_flag), 32'd0);
    repeat (S) @(negedge clk);
    check("t4_rise", 32'(update_flag), 32'd1);
    repeat (P) @(negedge clk);
    check("t4_fall", 32'(update_flag), 32'd0);
    check("t4_busy_hold", 32'(busy), 32'd1);
    repeat (H) @(negedge clk);
    check("t4_busy_end", 32'(busy), 32'd0);

    // Out-of-range source code
    write(3'd0, 16'd5);
`ifdef FRAME_SET_RANGE_CHECK_EN
    write(3'd4, 16'd0);
    check("t5_err",  32'(cfg_err), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_src",  32'(source_choose), 32'd3);
    @(negedge clk);
    check("t5_err_once", 32'(cfg_err), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
`else
    commit_pub('{3'd5, 16'h0400, 16'h0320, 16'h0040});
    check("t5_err",  32'(cfg_err), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_src",  32'(source_choose), 32'd5);
    wait_idle(40);
`endif
    @(negedge clk);

    // Minimum timing on the fast instance
    write(3'd0, 16'd2);
    commit_pub(p6);
    check("t6_k0_busy", 32'(f_busy), 32'd1);
    check("t6_k0_flag", 32'(f_flag), 32'd0);
    check("t6_src",     32'(f_src), 32'd2);
    @(negedge clk);
    check("t6_k1_flag", 32'(f_flag), 32'd1);
    check("t6_k1_busy", 32'(f_busy), 32'd1);
    @(negedge clk);
    check("t6_k2_flag", 32'(f_flag), 32'd0);
    check("t6_k2_busy", 32'(f_busy), 32'd1);
    @(negedge clk);
    check("t6_k3_busy", 32'(f_busy), 32'd0);
    wait_idle(40);
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
